led_pulse_stretcher: RTL and testbench

Output-side counterpart to the debounced switch edge detector. It turns single-cycle event pulses into human-visible LED blinks. Each accepted event produces one blink: exactly `ON_CYCLES` high, then at least `GAP_CYCLES` low. Events that arrive while a blink is in progress are queued in a saturating pending counter, so no event is lost until the counter is full. It sits between board-level event logic (edge detectors, toggles) and the LED pins.

---
 rtl/led_pulse_stretcher.sv | 125 ++++++++++++
 tb/tb_led_pulse_stretcher.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/led_pulse_stretcher.sv
// LED pulse stretcher: turns single-cycle events into visible blinks,
// with queued events held in a saturating pending counter.
module led_pulse_stretcher #(
    parameter int ON_CYCLES  = 2500000,
    parameter int GAP_CYCLES = 2500000,
    parameter int PEND_W     = 3
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_Event,
    output logic              o_LED,
    output logic              o_Busy,
    output logic [PEND_W-1:0] o_Pending,
    output logic              o_Overflow
);

    localparam int MAX_DUR = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_DUR + 1);

    localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [PEND_W-1:0] MAX_PEND = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_GAP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [PEND_W-1:0] r_pend;
    logic [PEND_W-1:0] w_pend_nxt;
    logic              r_led;
    logic              r_ovf;
    logic              w_start;
    logic              w_cnt_done;
    logic              w_has_pend;
    logic              w_drop;
    logic              w_accept;

    assign w_cnt_done = (r_cnt == '0);
    assign w_has_pend = (r_pend != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_has_pend) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_ON;
                    w_cnt_nxt   = ON_LOAD;
                end
            end
            S_ON: begin
                if (w_cnt_done) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = GAP_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_GAP: begin
                if (!w_cnt_done) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else if (w_has_pend) begin
                    // Back-to-back blink: skip IDLE to keep the period exact
                    w_start     = 1'b1;
                    w_state_nxt = S_ON;
                    w_cnt_nxt   = ON_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A full counter still accepts an event when a blink frees a slot
    assign w_drop   = i_Event && (r_pend == MAX_PEND) && !w_start;
    assign w_accept = i_Event && !w_drop;

    always_comb begin
        w_pend_nxt = r_pend;
        if (w_accept && !w_start) begin
            w_pend_nxt = r_pend + PEND_ONE;
        end else if (!w_accept && w_start) begin
            w_pend_nxt = r_pend - PEND_ONE;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_led   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_led   <= (w_state_nxt == S_ON);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_LED      = r_led;
    assign o_Busy     = (r_state != S_IDLE) || w_has_pend;
    assign o_Pending  = r_pend;
    assign o_Overflow = r_ovf;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Bench for led_pulse_stretcher: directed and random events compared
// against a timeline model of blink start times and queued events.
module tb_led_pulse_stretcher;

    localparam int ON     = 4;
    localparam int GAP    = 3;
    localparam int PW     = 2;
    localparam int MAXP   = 3;
    localparam int PERIOD = ON + GAP;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ev = 1'b0;
    logic          led;
    logic          busy;
    logic          ovf;
    logic [PW-1:0] pend;

    always #5 clk = ~clk;

    led_pulse_stretcher #(
        .ON_CYCLES (ON),
        .GAP_CYCLES(GAP),
        .PEND_W    (PW)
    ) dut (
        .i_Clk     (clk),
        .i_Rst_L   (rst_n),
        .i_Event   (ev),
        .o_LED     (led),
        .o_Busy    (busy),
        .o_Pending (pend),
        .o_Overflow(ovf)
    );

    int total = 0;
    int bad = 0;

    // Model: edge index, queued events, sticky overflow, blink timeline
    int n = 0;
    int m_pend = 0;
    bit m_ovf = 1'b0;
    int last_start = -1000;
    int next_free = 0;
    int led_cycles = 0;
    int led_rises = 0;
    logic led_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0;
        m_ovf = 1'b0;
        last_start = -1000;
        next_free = n;
        led_prev = 1'b0;
    endtask

    task automatic check_all(input string tag);
        bit m_led;
        bit m_busy;
        m_led  = (n >= last_start) && (n - last_start < ON);
        m_busy = (m_pend > 0) || (n < last_start + PERIOD);
        chk({tag, ".led"}, 32'(led), 32'(m_led));
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
        chk({tag, ".pend"}, 32'(pend), 32'(m_pend));
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    endtask

    task automatic tick(input bit e, input string tag);
        bit start;
        ev = e;
        @(posedge clk);
        start = (m_pend > 0) && (n >= next_free);
        if (start) begin
            last_start = n;
            next_free  = n + PERIOD;
            m_pend--;
        end
        if (e) begin
            if (m_pend + (start ? 1 : 0) == MAXP && !start) m_ovf = 1'b1;
            else m_pend++;
        end
        #1;
        check_all(tag);
        if (led === 1'b1) led_cycles++;
        if (led === 1'b1 && led_prev === 1'b0) led_rises++;
        led_prev = led;
        n++;
    endtask

    task automatic idle(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) tick(1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        ev = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, ".rled"}, 32'(led), 32'd0);
        chk({tag, ".rpend"}, 32'(pend), 32'd0);
        chk({tag, ".rbusy"}, 32'(busy), 32'd0);
        chk({tag, ".rovf"}, 32'(ovf), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #3;
        chk("por.led", 32'(led), 32'd0);
        chk("por.busy", 32'(busy), 32'd0);
        chk("por.pend", 32'(pend), 32'd0);
        chk("por.ovf", 32'(ovf), 32'd0);
        #9;
        rst_n = 1'b1;

        // Single event: 4 LED cycles, one blink
        led_cycles = 0;
        led_rises = 0;
        tick(1'b1, "single");
        idle(12, "single");
        chk("single.oncnt", 32'(led_cycles), 32'(ON));
        chk("single.rises", 32'(led_rises), 32'd1);

        // Three consecutive events: three blinks
        led_rises = 0;
        tick(1'b1, "three");
        tick(1'b1, "three");
        tick(1'b1, "three");
        idle(25, "three");
        chk("three.rises", 32'(led_rises), 32'd3);

        // Event on final GAP edge with one queued: no IDLE gap
        led_rises = 0;
        tick(1'b1, "coin");
        tick(1'b1, "coin");
        idle(6, "coin");
        tick(1'b1, "coin");
        chk("coin.led", 32'(led), 32'd1);
        chk("coin.pend", 32'(pend), 32'd1);
        idle(20, "coin");
        chk("coin.rises", 32'(led_rises), 32'd3);

        // Five consecutive events: fifth dropped
        led_rises = 0;
        for (int i = 0; i < 5; i++) tick(1'b1, "five");
        chk("five.ovf", 32'(ovf), 32'd1);
        idle(35, "five");
        chk("five.rises", 32'(led_rises), 32'd4);

        // Async reset mid-ON with two queued
        do_reset("clr");
        tick(1'b1, "mid");
        tick(1'b1, "mid");
        tick(1'b1, "mid");
        chk("mid.pend", 32'(pend), 32'd2);
        chk("mid.led", 32'(led), 32'd1);
        do_reset("mid");
        led_rises = 0;
        idle(15, "post");
        chk("post.rises", 32'(led_rises), 32'd0);

        // Held event for ten cycles
        for (int i = 0; i < 10; i++) tick(1'b1, "hold");
        idle(40, "hold");

        // Random traffic with one reset in the middle
        do_reset("rnd0");
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset("rndr");
            tick(($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0, "rnd");
        end
        idle(40, "tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
